sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Shares the single SRAM access port of the memory interface among three requesters: boot copier (flash-to-SRAM loader), data memory (dm) and instruction memory (im).
- Sequences one transaction at a time with a cs/done handshake toward the memory interface and per-requester done pulses.
- Adds a starvation guard for im and a watchdog timeout.
- Sits between the CPU/boot-loader side and the SRAM/flash memory interface, replacing the separate dual-port interface and source-select mux.

Parameters:
- ADDR_W, 22, SRAM word address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive dm grants allowed while im is waiting
- TIMEOUT, 255, ACCESS cycles without mem_done before abort (8-bit counter)

Ports:
- clk_in  in  1  sole clock, rising edge
- rst_in  in  1  synchronous, active-low reset
- boot_work  in  1  boot copier write request, held until boot_done
- boot_addr  in  ADDR_W  boot write address
- boot_data  in  DATA_W  boot write data
- boot_done  out  1  one-cycle completion pulse
- im_work  in  1  instruction fetch request (read only)
- im_addr  in  ADDR_W  fetch address
- im_dataout  out  DATA_W  registered fetch data
- im_done  out  1  one-cycle completion pulse
- dm_work  in  1  data request
- dm_we  in  1  1=write, 0=read
- dm_be  in  4  byte enables, active-high
- dm_addr  in  ADDR_W  data address
- dm_datain  in  DATA_W  write data
- dm_dataout  out  DATA_W  registered read data
- dm_done  out  1  one-cycle completion pulse
- mem_cs  out  1  transaction strobe toward memory interface
- mem_rw  out  1  1=read, 0=write
- mem_addr  out  ADDR_W  address
- mem_data_wr  out  DATA_W  write data
- mem_be  out  4  byte enables
- mem_data_rd  in  DATA_W  read data, valid with mem_done
- mem_done  in  1  one-cycle completion from memory interface
- bus_err  out  1  sticky timeout flag
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_in=0 at a clock edge): state IDLE. All outputs 0, including mem_cs, mem_rw, mem_addr, mem_data_wr, mem_be, every done pulse, both dataout registers, bus_err and busy. starve_cnt=0, tmo_cnt=0.
- A reset asserted mid-transaction abandons it immediately; no done pulse is issued.
- States: IDLE -> ACCESS -> RELEASE -> IDLE.
- IDLE, grant priority:
  - boot_work has absolute priority.
  - Otherwise im, if im_work and starve_cnt==STARVE_LIMIT.
  - Otherwise dm.
  - Otherwise im.
  - No request: stay in IDLE.
- On grant:
  - Latch the requester's addr, data and be, and the owner id, into the mem_* output registers.
  - Set mem_rw: boot=0, be 1111; im=1, be 1111; dm=~dm_we, dm_be.
  - Enter ACCESS with mem_cs=1 from the next cycle; request-to-cs latency is 1 cycle.
- mem_* outputs are stable for the whole of ACCESS. Requester inputs are ignored after the grant edge.
- ACCESS:
  - tmo_cnt increments each cycle.
  - On mem_done=1: capture mem_data_rd into the owner's dataout (reads only; the other dataout holds), drop mem_cs, go to RELEASE.
  - If tmo_cnt reaches TIMEOUT without mem_done: drop mem_cs, set bus_err, go to RELEASE; read data is not updated.
- RELEASE (exactly 1 cycle):
  - mem_cs=0; the owner's done pulse =1 (also on timeout). tmo_cnt cleared.
  - Return to IDLE.
  - Requesters drop work in the cycle after done, so it is already low when IDLE samples; no double-grant is possible.
- Minimum cs-low gap between transactions is 2 cycles (RELEASE + IDLE).
- Starvation counter:
  - Increments on each dm grant while im_work=1, saturating at STARVE_LIMIT.
  - Clears on any im grant, or when im_work=0 in IDLE.
  - Boot grants leave it unchanged.
- mem_done outside ACCESS is ignored.
- Simultaneous mem_done and timeout in the same cycle: mem_done wins; bus_err is not set.
- bus_err clears only on reset.
- Done pulses are mutually exclusive, at most one per transaction.

Test Plan:
- Reset: hold rst_in=0 for 3 cycles with all work=1 -> all outputs 0, state IDLE; after release the boot request is granted first (mem_cs=1 one cycle later, mem_rw=0, mem_be=1111).
- dm read: dm_work=1, dm_we=0, dm_addr=0x000123; memory model returns 0xDEADBEEF with mem_done 3 cycles after cs -> dm_done pulses the cycle after mem_done, dm_dataout=0xDEADBEEF, im_dataout unchanged.
- dm write with dm_be=0011 -> mem_rw=0, mem_be=0011, mem_data_wr=dm_datain; dm_dataout unchanged.
- Starvation: im_work and dm_work both held high continuously -> grant order dm,dm,dm,dm,im,dm,dm,dm,dm,im.
- Timeout: memory model never returns mem_done -> mem_cs drops after 255 ACCESS cycles, owner done pulses, bus_err=1 and stays 1 through later successful transactions.
- Reset mid-ACCESS: assert rst_in=0 while mem_cs=1 -> next cycle mem_cs=0, no done pulse; after reset release a pending im request completes normally.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Purpose: shares the SRAM port among boot copier, im and dm, with an im starvation guard and an access watchdog.
// Latency: request to mem_cs is 1 cycle; the done pulse comes 1 cycle after mem_done (or after the timeout).
// Backpressure: requesters hold *_work until their done pulse; only one transaction is in flight at a time.
module sram_port_arbiter #(
  parameter int ADDR_W       = 22,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              boot_work,
  input  logic [ADDR_W-1:0] boot_addr,
  input  logic [DATA_W-1:0] boot_data,
  output logic              boot_done,
  input  logic              im_work,
  input  logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_dataout,
  output logic              im_done,
  input  logic              dm_work,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_datain,
  output logic [DATA_W-1:0] dm_dataout,
  output logic              dm_done,
  output logic              mem_cs,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_wr,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_data_rd,
  input  logic              mem_done,
  output logic              bus_err,
  output logic              busy
);

  localparam int              SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
  // The abort fires on the edge that ends the TIMEOUT-th ACCESS cycle.
  localparam logic [7:0]      TMO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RELEASE = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_BOOT = 2'd1, OWN_IM = 2'd2, OWN_DM = 2'd3} owner_t;

  state_t        r_state;
  state_t        w_state_nxt;
  owner_t        r_owner;
  owner_t        w_grant;
  logic [SW-1:0] r_starve_cnt;
  logic [7:0]    r_tmo_cnt;
  logic          w_mem_ok;
  logic          w_timeout;
  logic          w_finish;

  assign busy     = (r_state != S_IDLE);
  assign w_finish = w_mem_ok | w_timeout;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state, grant selection and access termination (mem_done beats the timeout).
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = OWN_NONE;
    w_mem_ok    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (boot_work)                                w_grant = OWN_BOOT;
        else if (im_work && r_starve_cnt == STARVE_MAX) w_grant = OWN_IM;
        else if (dm_work)                             w_grant = OWN_DM;
        else if (im_work)                             w_grant = OWN_IM;
        if (w_grant != OWN_NONE) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (mem_done) begin
          w_mem_ok    = 1'b1;
          w_state_nxt = S_RELEASE;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch the winner on grant, capture read data, raise done for the RELEASE cycle.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      mem_cs       <= 1'b0;
      mem_rw       <= 1'b0;
      mem_addr     <= '0;
      mem_data_wr  <= '0;
      mem_be       <= '0;
      boot_done    <= 1'b0;
      im_done      <= 1'b0;
      dm_done      <= 1'b0;
      im_dataout   <= '0;
      dm_dataout   <= '0;
      bus_err      <= 1'b0;
      r_owner      <= OWN_NONE;
      r_starve_cnt <= '0;
      r_tmo_cnt    <= '0;
    end else begin
      boot_done <= 1'b0;
      im_done   <= 1'b0;
      dm_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant != OWN_NONE) begin
            mem_cs    <= 1'b1;
            r_owner   <= w_grant;
            r_tmo_cnt <= '0;
          end
          case (w_grant)
            OWN_BOOT: begin
              mem_rw      <= 1'b0;
              mem_addr    <= boot_addr;
              mem_data_wr <= boot_data;
              mem_be      <= 4'hF;
            end
            OWN_IM: begin
              mem_rw      <= 1'b1;
              mem_addr    <= im_addr;
              mem_data_wr <= '0;
              mem_be      <= 4'hF;
            end
            OWN_DM: begin
              mem_rw      <= ~dm_we;
              mem_addr    <= dm_addr;
              mem_data_wr <= dm_datain;
              mem_be      <= dm_be;
            end
            default: ;
          endcase
          // Count dm wins only while im is actually waiting; boot grants do not count.
          if (!im_work || w_grant == OWN_IM)
            r_starve_cnt <= '0;
          else if (w_grant == OWN_DM && r_starve_cnt != STARVE_MAX)
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
        S_ACCESS: begin
          r_tmo_cnt <= r_tmo_cnt + 8'd1;
          if (w_finish) begin
            mem_cs    <= 1'b0;
            boot_done <= (r_owner == OWN_BOOT);
            im_done   <= (r_owner == OWN_IM);
            dm_done   <= (r_owner == OWN_DM);
          end
          if (w_mem_ok && mem_rw) begin
            if (r_owner == OWN_IM) im_dataout <= mem_data_rd;
            if (r_owner == OWN_DM) dm_dataout <= mem_data_rd;
          end
          if (w_timeout) bus_err <= 1'b1;
        end
        S_RELEASE: r_tmo_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule
